// File: rtl/spec_acc_peak_engine.sv
// Multi-pulse spectrum accumulator with optional background (bin 0) deduction
// and one peak report per range bin; results stay in RAM for readout.
module spec_acc_peak_engine #(
    parameter int PS_WIDTH   = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int LOG2_NFFT  = 10,
    parameter int LOG2_NBINS = 4,
    parameter int PULSE_W    = 16,
    parameter int KMIN       = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [PULSE_W-1:0]              cfg_pulses_i,
    input  logic                            cfg_bg_en_i,
    input  logic                            ps_valid_i,
    input  logic [PS_WIDTH-1:0]             ps_data_i,
    input  logic [LOG2_NFFT-1:0]            ps_index_i,
    input  logic [LOG2_NBINS-1:0]           ps_bin_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            peak_valid_o,
    output logic [LOG2_NBINS-1:0]           peak_bin_o,
    output logic [LOG2_NFFT-1:0]            peak_addr_o,
    output logic [ACC_WIDTH-1:0]            peak_value_o,
    input  logic [LOG2_NBINS+LOG2_NFFT-1:0] rd_addr_i,
    output logic [ACC_WIDTH-1:0]            rd_data_o
);
    localparam int AW   = LOG2_NBINS + LOG2_NFFT;
    localparam int NFFT = 1 << LOG2_NFFT;
    localparam logic [LOG2_NFFT-1:0]  KLO      = LOG2_NFFT'(KMIN);
    localparam logic [LOG2_NFFT-1:0]  KHI      = LOG2_NFFT'(NFFT / 2 - 1);
    localparam logic [LOG2_NFFT-1:0]  IDX_LAST = '1;
    localparam logic [LOG2_NBINS-1:0] BIN_LAST = '1;

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_BG_SUB, S_PEAK, S_DONE} state_t;

    state_t                 state;
    logic [PULSE_W-1:0]     cfg_pulses_q, pulse_cnt;
    logic                   bg_en_q;
    logic [1:0]             drain;
    logic [LOG2_NBINS-1:0]  scan_bin;
    logic [LOG2_NFFT-1:0]   scan_idx;

    logic [ACC_WIDTH-1:0]   mem [0:(2**AW)-1];
    logic [AW-1:0]          rd_a_addr, rd_b_addr;
    logic [ACC_WIDTH-1:0]   ra_q, rb_q;

    logic                   s1_valid, s1_is_bg, s1_first;
    logic [AW-1:0]          s1_addr;
    logic [PS_WIDTH-1:0]    s1_data;
    logic                   s2_valid;
    logic [AW-1:0]          s2_addr;
    logic [ACC_WIDTH-1:0]   s2_data, wr_next;
    logic [ACC_WIDTH:0]     sum_w;

    logic                   pk1_valid, pk1_first, pk1_last;
    logic [LOG2_NFFT-1:0]   pk1_idx, cur_idx;
    logic [LOG2_NBINS-1:0]  pk1_bin, pk2_bin;
    logic                   pk2_last;
    logic [ACC_WIDTH-1:0]   cur_max;

    // Port A serves the sample stream, the scans and idle readout; port B only
    // ever reads bin 0, which is never written while BG_SUB runs.
    always_comb begin
        rd_a_addr = rd_addr_i;
        case (state)
            S_ACC:            rd_a_addr = {ps_bin_i, ps_index_i};
            S_BG_SUB, S_PEAK: rd_a_addr = {scan_bin, scan_idx};
            default:          rd_a_addr = rd_addr_i;
        endcase
    end
    assign rd_b_addr = {{LOG2_NBINS{1'b0}}, scan_idx};

    assign sum_w = {1'b0, ra_q} + (ACC_WIDTH + 1)'(s1_data);

    always_comb begin
        wr_next = '0;
        if (s1_is_bg)
            wr_next = (ra_q > rb_q) ? ra_q - rb_q : '0;
        else if (s1_first)
            wr_next = ACC_WIDTH'(s1_data);
        else
            wr_next = sum_w[ACC_WIDTH] ? '1 : sum_w[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (s2_valid)
            mem[s2_addr] <= s2_data;
        ra_q <= mem[rd_a_addr];
        rb_q <= mem[rd_b_addr];
    end

    // ps_valid_i is a valid-only stream with no backpressure: every sample
    // presented while ACC is not draining is consumed in that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            peak_valid_o <= 1'b0;
            peak_bin_o   <= '0;
            peak_addr_o  <= '0;
            peak_value_o <= '0;
            rd_data_o    <= '0;
            pulse_cnt    <= '0;
            cfg_pulses_q <= '0;
            bg_en_q      <= 1'b0;
            drain        <= '0;
            scan_bin     <= '0;
            scan_idx     <= '0;
            s1_valid     <= 1'b0;
            s1_is_bg     <= 1'b0;
            s1_first     <= 1'b0;
            s1_addr      <= '0;
            s1_data      <= '0;
            s2_valid     <= 1'b0;
            s2_addr      <= '0;
            s2_data      <= '0;
            pk1_valid    <= 1'b0;
            pk1_first    <= 1'b0;
            pk1_last     <= 1'b0;
            pk1_idx      <= '0;
            pk1_bin      <= '0;
            pk2_last     <= 1'b0;
            pk2_bin      <= '0;
            cur_max      <= '0;
            cur_idx      <= '0;
        end else begin
            s1_valid     <= 1'b0;
            s2_valid     <= s1_valid;
            s2_addr      <= s1_addr;
            s2_data      <= wr_next;
            pk1_valid    <= 1'b0;
            pk2_last     <= pk1_valid && pk1_last;
            pk2_bin      <= pk1_bin;
            peak_valid_o <= 1'b0;

            // Strict greater-than keeps the lowest index on ties.
            if (pk1_valid && (pk1_first || ra_q > cur_max)) begin
                cur_max <= ra_q;
                cur_idx <= pk1_idx;
            end
            if (pk2_last) begin
                peak_valid_o <= 1'b1;
                peak_bin_o   <= pk2_bin;
                peak_addr_o  <= cur_idx;
                peak_value_o <= cur_max;
            end
            if (state == S_IDLE || state == S_DONE)
                rd_data_o <= ra_q;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        cfg_pulses_q <= (cfg_pulses_i == '0) ? PULSE_W'(1) : cfg_pulses_i;
                        bg_en_q      <= cfg_bg_en_i;
                        pulse_cnt    <= '0;
                        drain        <= '0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        state        <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (drain != '0) begin
                        drain <= drain - 2'd1;
                        if (drain == 2'd1) begin
                            state    <= bg_en_q ? S_BG_SUB : S_PEAK;
                            scan_bin <= bg_en_q ? LOG2_NBINS'(1) : '0;
                            scan_idx <= bg_en_q ? '0 : KLO;
                        end
                    end else if (ps_valid_i) begin
                        s1_valid <= 1'b1;
                        s1_is_bg <= 1'b0;
                        s1_first <= (pulse_cnt == '0);
                        s1_addr  <= {ps_bin_i, ps_index_i};
                        s1_data  <= ps_data_i;
                        if (ps_bin_i == BIN_LAST && ps_index_i == IDX_LAST) begin
                            pulse_cnt <= pulse_cnt + PULSE_W'(1);
                            if (pulse_cnt + PULSE_W'(1) == cfg_pulses_q)
                                drain <= 2'd2;
                        end
                    end
                end
                S_BG_SUB: begin
                    if (drain != '0) begin
                        drain <= drain - 2'd1;
                        if (drain == 2'd1) begin
                            state    <= S_PEAK;
                            scan_bin <= LOG2_NBINS'(1);
                            scan_idx <= KLO;
                        end
                    end else begin
                        s1_valid <= 1'b1;
                        s1_is_bg <= 1'b1;
                        s1_first <= 1'b0;
                        s1_addr  <= {scan_bin, scan_idx};
                        scan_idx <= scan_idx + 1'b1;
                        if (scan_idx == IDX_LAST) begin
                            scan_bin <= scan_bin + 1'b1;
                            if (scan_bin == BIN_LAST)
                                drain <= 2'd2;
                        end
                    end
                end
                S_PEAK: begin
                    if (drain != '0) begin
                        drain <= drain - 2'd1;
                        if (drain == 2'd1) begin
                            state  <= S_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end else begin
                        pk1_valid <= 1'b1;
                        pk1_first <= (scan_idx == KLO);
                        pk1_last  <= (scan_idx == KHI);
                        pk1_idx   <= scan_idx;
                        pk1_bin   <= scan_bin;
                        if (scan_idx == KHI) begin
                            scan_idx <= KLO;
                            scan_bin <= scan_bin + 1'b1;
                            if (scan_bin == BIN_LAST)
                                drain <= 2'd3;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spec_acc_peak_engine.sv
// Scoreboard bench for spec_acc_peak_engine at NFFT=16, NBINS=4: a behavioural
// RAM model predicts readout words and the queue of peak reports.
module tb_spec_acc_peak_engine;
    localparam int PS_W = 32, ACC_W = 32, LNFFT = 4, LNBINS = 2, PW = 16, KMIN = 1;
    localparam int NFFT = 16, NBINS = 4, NWORDS = 64;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [PW-1:0]     cfg_pulses_i = '0;
    logic              cfg_bg_en_i = 1'b0;
    logic              ps_valid_i = 1'b0;
    logic [PS_W-1:0]   ps_data_i = '0;
    logic [LNFFT-1:0]  ps_index_i = '0;
    logic [LNBINS-1:0] ps_bin_i = '0;
    logic [5:0]        rd_addr_i = '0;
    logic              busy_o, done_o, peak_valid_o;
    logic [LNBINS-1:0] peak_bin_o;
    logic [LNFFT-1:0]  peak_addr_o;
    logic [ACC_W-1:0]  peak_value_o, rd_data_o;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] model_mem [NWORDS];
    logic [PS_W-1:0]  pat [NWORDS];
    logic [37:0]      exp_q [$];

    spec_acc_peak_engine #(
        .PS_WIDTH(PS_W), .ACC_WIDTH(ACC_W), .LOG2_NFFT(LNFFT),
        .LOG2_NBINS(LNBINS), .PULSE_W(PW), .KMIN(KMIN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .cfg_pulses_i(cfg_pulses_i), .cfg_bg_en_i(cfg_bg_en_i),
        .ps_valid_i(ps_valid_i), .ps_data_i(ps_data_i),
        .ps_index_i(ps_index_i), .ps_bin_i(ps_bin_i),
        .busy_o(busy_o), .done_o(done_o), .peak_valid_o(peak_valid_o),
        .peak_bin_o(peak_bin_o), .peak_addr_o(peak_addr_o),
        .peak_value_o(peak_value_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each strobe pops the next predicted {bin, addr, value}
    always @(negedge clk_i) begin
        if (peak_valid_o) begin
            if (exp_q.size() == 0)
                check("peak_unexpected", 64'(exp_q.size()), 64'd1);
            else
                check("peak", {peak_bin_o, peak_addr_o, peak_value_o}, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_group(input int pulses, input logic bg);
        cfg_pulses_i = PW'(pulses);
        cfg_bg_en_i  = bg;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        @(negedge clk_i);
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic send_pulse(input bit first, input int stop_at);
        logic [32:0] s;
        for (int a = 0; a < NWORDS; a++) begin
            if (a == stop_at) begin
                ps_valid_i = 1'b0;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                ps_valid_i = 1'b0;
                tick();
            end
            ps_valid_i = 1'b1;
            ps_bin_i   = a[5:4];
            ps_index_i = a[3:0];
            ps_data_i  = pat[a];
            tick();
            ps_valid_i = 1'b0;
            if (first) begin
                model_mem[a] = pat[a];
            end else begin
                s = {1'b0, model_mem[a]} + {1'b0, pat[a]};
                model_mem[a] = s[32] ? 32'hFFFF_FFFF : s[31:0];
            end
        end
    endtask

    task automatic model_bg();
        for (int b = 1; b < NBINS; b++)
            for (int k = 0; k < NFFT; k++)
                model_mem[b*NFFT+k] = (model_mem[b*NFFT+k] > model_mem[k]) ?
                                      model_mem[b*NFFT+k] - model_mem[k] : 32'd0;
    endtask

    task automatic push_peaks(input logic bg);
        for (int b = (bg ? 1 : 0); b < NBINS; b++) begin
            logic [31:0] best;
            int bi;
            best = model_mem[b*NFFT+KMIN];
            bi   = KMIN;
            for (int k = KMIN + 1; k < NFFT / 2; k++)
                if (model_mem[b*NFFT+k] > best) begin
                    best = model_mem[b*NFFT+k];
                    bi   = k;
                end
            exp_q.push_back({2'(b), 4'(bi), best});
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 3000) begin
            tick();
            n++;
        end
        @(negedge clk_i);
        check({tag, "_done"}, done_o, 1);
        check({tag, "_busy_low"}, busy_o, 0);
        check({tag, "_peaks_left"}, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
        rd_addr_i = 6'(addr);
        tick();
        tick();
        @(negedge clk_i);
        check(tag, rd_data_o, exp);
    endtask

    task automatic run_group(input int pulses, input logic bg, input string tag);
        int np;
        np = (pulses == 0) ? 1 : pulses;
        start_group(pulses, bg);
        for (int p = 0; p < np; p++)
            send_pulse(p == 0, NWORDS);
        if (bg)
            model_bg();
        push_peaks(bg);
        wait_done(tag);
    endtask

    initial begin
        // Reset values while reset is held
        repeat (3) tick();
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_peak_valid", peak_valid_o, 0);
        check("rst_peak_value", peak_value_o, 0);
        check("rst_peak_addr", peak_addr_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        rst_i = 1'b0;
        tick();

        // Basic accumulation: 3 pulses of k+1
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'(a % NFFT + 1);
        run_group(3, 1'b0, "basic");
        read_check("basic_b2k5", 37, 32'd18);
        for (int i = 0; i < 6; i++) begin
            int a;
            a = $urandom_range(0, NWORDS - 1);
            read_check("basic_rd", a, model_mem[a]);
        end

        // Saturation
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'hC000_0000;
        run_group(2, 1'b0, "sat");
        for (int a = 0; a < NWORDS; a++) read_check("sat_rd", a, 32'hFFFF_FFFF);

        // Background subtraction
        for (int k = 0; k < NFFT; k++) begin
            pat[k]          = 32'd5;
            pat[NFFT+k]     = 32'd3;
            pat[2*NFFT+k]   = 32'(k + 5);
            pat[3*NFFT+k]   = 32'd0;
        end
        run_group(1, 1'b1, "bg");
        read_check("bg_b2k7", 2*NFFT+7, 32'd7);
        read_check("bg_b0k3", 3, 32'd5);
        for (int a = 0; a < NWORDS; a++) read_check("bg_rd", a, model_mem[a]);

        // Tie and DC exclusion in bin 0
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'($urandom_range(0, 1000));
        for (int k = 0; k < NFFT; k++)
            pat[k] = (k == 0) ? 32'd100 : ((k == 2 || k == 6) ? 32'd50 : 32'd1);
        run_group(1, 1'b0, "tie");

        // Reset mid-ACC, then a fresh single-pulse group of 9s
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'($urandom_range(1, 1 << 20));
        start_group(4, 1'b0);
        send_pulse(1'b1, NWORDS);
        send_pulse(1'b0, 20);
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        rst_i = 1'b0;
        tick();
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'd9;
        run_group(1, 1'b0, "post_rst");
        for (int a = 0; a < NWORDS; a += 5) read_check("post_rst_rd", a, 32'd9);

        // Start while busy is ignored: 2-pulse group must still accumulate
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'($urandom_range(0, 5000));
        start_group(2, 1'b0);
        send_pulse(1'b1, NWORDS);
        cfg_pulses_i = PW'(5);
        cfg_bg_en_i  = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        send_pulse(1'b0, NWORDS);
        push_peaks(1'b0);
        wait_done("ignore_start");
        for (int i = 0; i < 4; i++) begin
            int a;
            a = $urandom_range(0, NWORDS - 1);
            read_check("ignore_start_rd", a, model_mem[a]);
        end

        // cfg_pulses = 0 completes after one pulse
        for (int a = 0; a < NWORDS; a++) pat[a] = 32'($urandom_range(0, 300));
        run_group(0, 1'b0, "zero_cfg");
        read_check("zero_cfg_rd", 17, model_mem[17]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spec_acc_peak_engine.md
Name: spec_acc_peak_engine

Overview:
Parametrised successor to the fixed 16x1024 accumulate, background-deduction and peak-detection chain. Takes a streamed power spectrum (one range bin of one pulse at a time) and accumulates a configurable number of pulses into an internal RAM of NBINS x NFFT words. It then optionally subtracts the background bin (bin 0) from every other bin and reports one spectral peak per range bin. It sits between the power-spectrum calculator and the readout/DMA logic.

Parameters:
PS_WIDTH, 32, width of the input power-spectrum sample (unsigned).
ACC_WIDTH, 32, accumulator/RAM word width; must be >= PS_WIDTH.
LOG2_NFFT, 10, log2 of FFT length (NFFT points per bin).
LOG2_NBINS, 4, log2 of number of range bins.
PULSE_W, 16, width of pulse-count configuration.
KMIN, 1, lowest FFT index included in the peak search (excludes DC).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse; begins a new accumulation group
cfg_pulses_i  in  PULSE_W  pulses per group; sampled on accepted start_i
cfg_bg_en_i  in  1  enable background subtraction; sampled on accepted start_i
ps_valid_i  in  1  input sample valid
ps_data_i  in  PS_WIDTH  power-spectrum sample
ps_index_i  in  LOG2_NFFT  FFT index of sample
ps_bin_i  in  LOG2_NBINS  range bin of sample
busy_o  out  1  high from accepted start_i until done_o rises
done_o  out  1  level; high in DONE state
peak_valid_o  out  1  one-cycle strobe per reported bin
peak_bin_o  out  LOG2_NBINS  bin of the reported peak
peak_addr_o  out  LOG2_NFFT  FFT index of the peak
peak_value_o  out  ACC_WIDTH  peak magnitude
rd_addr_i  in  LOG2_NBINS+LOG2_NFFT  readout address {bin,index}
rd_data_o  out  ACC_WIDTH  readout data

Behaviour:
- Reset:
  - state IDLE.
  - busy_o, done_o and peak_valid_o = 0.
  - peak_bin_o, peak_addr_o, peak_value_o and rd_data_o = 0.
  - Pulse counter = 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts immediately to IDLE.
- States: IDLE -> ACC -> (BG_SUB if bg_en) -> PEAK -> DONE. DONE is left only by start_i or reset.
- start_i:
  - Accepted only in IDLE or DONE; ignored otherwise.
  - cfg_pulses_i = 0 is treated as 1.
- ACC:
  - Read-modify-write pipeline: read at cycle t, write at t+2. Fully pipelined, one sample per cycle.
  - First pulse of a group overwrites (acc = ps_data, zero-extended). Later pulses compute acc = old + ps_data, saturating at 2^ACC_WIDTH-1.
  - Input order within a pulse is bin-major, index ascending; gaps in ps_valid_i are allowed. Consecutive writes therefore never hit the same address, and no forwarding is required.
  - A pulse ends on a valid sample with bin = NBINS-1 and index = NFFT-1, which increments the pulse counter.
  - When the counter reaches the configured count, drain the 2-cycle pipeline, then change state.
  - ps_valid_i outside ACC is ignored.
- BG_SUB:
  - For bins 1..NBINS-1 and each index k: acc[b][k] = acc[b][k] > bg[k] ? acc - bg : 0, where bg = bin 0 (clamp at 0).
  - One word per cycle, same 2-cycle pipeline.
  - Bin 0 is left unchanged.
  - Duration: (NBINS-1)*NFFT + 2 cycles.
- PEAK:
  - Scans bins 1..NBINS-1 when bg_en, else 0..NBINS-1.
  - Per bin, reads indices KMIN..NFFT/2-1 at one per cycle and tracks the maximum with strict greater-than, so ties keep the lowest index.
  - peak_valid_o pulses once per bin, 3 cycles after that bin's last read, with peak_bin_o, peak_addr_o and peak_value_o valid in the same cycle. These outputs hold until the next strobe.
  - Bins are reported in ascending order.
- DONE: done_o = 1, busy_o = 0. Both are registered and change in the same cycle.
- Readout:
  - rd_data_o = RAM[rd_addr_i], 2-cycle latency (RAM register plus output register).
  - Valid only in IDLE/DONE. In other states rd_data_o holds its last value.
- The RAM is a single dual-port inferred block (1 write port, 1 read port) of 2^(LOG2_NBINS+LOG2_NFFT) words. Bin 0 is read through a second read port, or a second copy, during BG_SUB.

Test Plan:
(All scenarios: LOG2_NFFT=4, LOG2_NBINS=2, KMIN=1, ACC_WIDTH=PS_WIDTH=32.)
- Basic accumulation:
  - Stimulus: cfg_pulses=3, bg off, ps_data=k+1 in every bin, 3 pulses.
  - Required: RAM[{2,5}]=18. Four peak strobes, bins 0..3, each peak_addr=7, value=24. Then done_o=1, busy_o=0.
- Saturation:
  - Stimulus: cfg_pulses=2, ps_data=0xC0000000 everywhere.
  - Required: every word = 0xFFFFFFFF. Peak_addr=1 (tie rule).
- Background subtraction:
  - Stimulus: bg on, cfg_pulses=1, bin0=5, bin1=3, bin2=k+5, bin3=0.
  - Required: bin1 all 0; bin2[k]=k; bin3 all 0; bin0 still 5. Peaks reported for bins 1..3 only, bin2 peak addr 7 value 7.
- Tie and DC exclusion:
  - Stimulus: cfg_pulses=1, bin0 with k0=100, k2=k6=50, rest 1.
  - Required: bin0 peak_addr=2, value=50.
- Reset mid-ACC:
  - Stimulus: assert rst_i mid-ACC, then start with cfg_pulses=1 and data=9.
  - Required: all words read back 9. No stale accumulation, busy_o=0 right after reset.
- Control edge cases:
  - Stimulus: start_i pulsed while busy; cfg_pulses=0 on start.
  - Required: the second start is ignored, with no restart and no counter reset. The group with cfg_pulses=0 completes after exactly 1 pulse.
